uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

UART receive framer that sits directly downstream of the start-bit detector. It is armed by `start_bit_detected` and re-checks the start bit at mid-bit. It then samples `DATA_BITS` data bits LSB-first at mid-bit spacing and checks the stop bit. It delivers each byte with a one-cycle valid pulse, or flags a framing error.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit period; integer ≥ 4.
- `DATA_BITS`, default 8: data bits per frame; 5 to 9.
- `clock` input, 1 bit: system clock; all logic on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `rx_in` input, 1 bit: serial line, idle high; already synchronous to `clock`.
- `start_bit_detected` input, 1 bit: high while `rx_in` is low, from the upstream detector.
- `rx_data` output, `DATA_BITS` bits: last correctly framed word.
- `rx_valid` output, 1 bit: one-cycle pulse when `rx_data` is updated.
- `framing_error` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- States: IDLE, START, DATA, STOP.
- Internal state:
  - `bit_cnt`: width $clog2(CLKS_PER_BIT), counts cycles within a bit period.
  - `bit_idx`: width $clog2(DATA_BITS+1).
  - Shift register: `DATA_BITS` wide.
- IDLE:
  - `start_bit_detected`=1 → START, `bit_cnt`=0.
  - Otherwise stay in IDLE.
- START:
  - `bit_cnt` increments each cycle.
  - When `bit_cnt` = CLKS_PER_BIT/2−1 (integer division), sample `rx_in`.
    - `rx_in`=1 → false start; go to IDLE with no output pulse.
    - `rx_in`=0 → DATA, `bit_cnt`=0, `bit_idx`=0.
- DATA:
  - When `bit_cnt` = CLKS_PER_BIT−1, sample `rx_in` into the shift register, LSB first (shift right, new bit enters at the MSB).
  - At the same edge: `bit_cnt`=0, `bit_idx`+1.
  - After the `DATA_BITS`-th sample → STOP.
- STOP:
  - When `bit_cnt` = CLKS_PER_BIT−1, sample `rx_in`, then go to IDLE.
  - `rx_in`=1: load `rx_data` from the shift register and pulse `rx_valid`.
  - `rx_in`=0: pulse `framing_error`; `rx_data` keeps its old value.
- `start_bit_detected` is ignored outside IDLE.
- Break condition (line held low): after a framing error the block returns to IDLE, sees `start_bit_detected`=1, and re-arms. Repeated framing errors are allowed.
- Reset mid-frame: all state is cleared immediately and the partial frame is discarded. No pulse is produced, either during reset or after it deasserts.

## Timing
- Reset values:
  - `rx_data` = 0.
  - `rx_valid`, `framing_error`, `busy` = 0.
  - State = IDLE; counters = 0.
- Let E0 be the rising edge at which `start_bit_detected`=1 is sampled in IDLE. Let H = CLKS_PER_BIT/2, N = CLKS_PER_BIT.
- `busy` is high from the cycle after E0.
- Start re-check at edge E0+H.
- Data bit k (k = 0..DATA_BITS−1) sampled at edge E0+H+(k+1)·N.
- Stop bit sampled at edge E0+H+(DATA_BITS+1)·N.
  - `rx_valid` or `framing_error` is high for exactly the following cycle.
  - `rx_data` changes at that same edge.
  - `busy` falls at that same edge.
- The next frame can be accepted at the edge immediately after the stop sample; no dead cycle is required.
- `rx_valid` and `framing_error` are never high together.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Nominal byte (N=16, DATA_BITS=8): send 0xA5 as start 0, bits 1,0,1,0,0,1,0,1, stop 1.
  - Expect `rx_data`=0xA5 and a single `rx_valid` pulse after edge E0+152.
  - `busy` high for 152 cycles.
- Glitch: `rx_in` low for 4 cycles, then high.
  - Expect no pulse and `busy` low again after edge E0+8.
  - `rx_data` unchanged.
- Framing error: send 0x3C with stop bit 0.
  - Expect one `framing_error` pulse at the same timing as a nominal `rx_valid`.
  - `rx_data` holds the previous 0xA5.
- Back-to-back: frames 0x00 and 0xFF with no idle gap between them.
  - Expect two `rx_valid` pulses exactly 160 cycles apart, with `rx_data` 0x00 then 0xFF.
- Reset mid-frame: assert `reset` during data bit 3 of 0x55, then release.
  - Expect all outputs 0 immediately and no pulse afterwards.
  - A following 0x81 frame is received correctly.
- Parameter sweep: DATA_BITS=7, CLKS_PER_BIT=5 (H=2).
  - Send 0x41; expect `rx_data`=0x41 with `rx_valid` after edge E0+2+8·5 = E0+42.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framer that re-checks the start bit, shifts in DATA_BITS LSB-first and validates the stop bit.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx_in,
   input  logic                 start_bit_detected,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 framing_error,
   output logic                 busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state, state_n;
   logic [CW-1:0]        bit_cnt, bit_cnt_n;
   logic [IW-1:0]        bit_idx, bit_idx_n;
   logic [DATA_BITS-1:0] shift, shift_n, rx_data_n;
   logic                 valid_n, ferr_n;

   assign busy = state != IDLE;

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         state         <= state_n;
         bit_cnt       <= bit_cnt_n;
         bit_idx       <= bit_idx_n;
         shift         <= shift_n;
         rx_data       <= rx_data_n;
         rx_valid      <= valid_n;
         framing_error <= ferr_n;
      end

   // Start re-check lands at mid-bit; every later sample is one full bit period on.
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt + 1'b1;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      rx_data_n = rx_data;
      valid_n   = 1'b0;
      ferr_n    = 1'b0;
      case (state)
         IDLE: begin
            bit_cnt_n = '0;
            state_n   = start_bit_detected ? START : IDLE;
         end
         START: if (bit_cnt == HALF) begin
            state_n   = rx_in ? IDLE : DATA;
            bit_cnt_n = '0;
            bit_idx_n = '0;
         end
         DATA: if (bit_cnt == LAST) begin
            shift_n   = {rx_in, shift[DATA_BITS-1:1]};
            bit_cnt_n = '0;
            bit_idx_n = bit_idx + 1'b1;
            state_n   = bit_idx == IDX_LAST ? STOP : DATA;
         end
         STOP: if (bit_cnt == LAST) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            valid_n   = rx_in;
            ferr_n    = !rx_in;
            rx_data_n = rx_in ? shift : rx_data;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed checks of the UART framer at 16x/8-bit and 5x/7-bit configurations.
module tb_uart_rx_frame;
   logic clock = 1'b0, reset = 1'b1, rx = 1'b1, rx7 = 1'b1;
   logic sbd, sbd7;
   logic [7:0] rx_data;
   logic rx_valid, framing_error, busy;
   logic [6:0] d7;
   logic v7, f7, b7;
   int cyc = 0, checks = 0, passed = 0, busy_total = 0, both_cnt = 0;
   int v_cyc[$], f_cyc[$], v7_cyc[$];
   logic [7:0] v_dat[$];

   assign sbd  = ~rx;
   assign sbd7 = ~rx7;

   uart_rx_frame u_dut (
      .clock(clock), .reset(reset), .rx_in(rx), .start_bit_detected(sbd),
      .rx_data(rx_data), .rx_valid(rx_valid), .framing_error(framing_error), .busy(busy));

   uart_rx_frame #(.CLKS_PER_BIT(5), .DATA_BITS(7)) u_dut7 (
      .clock(clock), .reset(reset), .rx_in(rx7), .start_bit_detected(sbd7),
      .rx_data(d7), .rx_valid(v7), .framing_error(f7), .busy(b7));

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Log pulses with the index of the edge that produced them.
   always @(posedge clock) begin
      #2;
      if (rx_valid) begin
         v_cyc.push_back(cyc);
         v_dat.push_back(rx_data);
      end
      if (framing_error) f_cyc.push_back(cyc);
      if (rx_valid && framing_error) both_cnt++;
      if (busy) busy_total++;
      if (v7) v7_cyc.push_back(cyc);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic send_bits(input logic [15:0] pat, input int nb, input int n, input bit sel, output int e0);
      e0 = cyc + 1;
      for (int i = 0; i < nb; i++) begin
         if (sel) rx7 = pat[i];
         else rx = pat[i];
         repeat (n) @(posedge clock);
         #1;
      end
      if (sel) rx7 = 1'b1;
      else rx = 1'b1;
   endtask

   initial begin
      int e0, e1, nv, nf, bb, n7;
      repeat (3) @(posedge clock);
      #1;
      check("rst_data", rx_data, 8'h00);
      check("rst_valid", rx_valid, 1'b0);
      check("rst_ferr", framing_error, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_data7", d7, 7'h00);
      check("rst_busy7", b7, 1'b0);
      reset = 1'b0;
      repeat (4) @(posedge clock);
      #1;

      nv = v_cyc.size(); nf = f_cyc.size(); bb = busy_total;
      send_bits({1'b1, 8'hA5, 1'b0}, 10, 16, 0, e0);
      repeat (4) @(posedge clock);
      #1;
      check("nom_valid_cnt", v_cyc.size() - nv, 1);
      check("nom_valid_edge", v_cyc[nv], e0 + 152);
      check("nom_data", rx_data, 8'hA5);
      check("nom_busy_cycles", busy_total - bb, 152);
      check("nom_no_ferr", f_cyc.size() - nf, 0);

      nv = v_cyc.size(); nf = f_cyc.size(); bb = busy_total;
      e0 = cyc + 1;
      rx = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      rx = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      check("glitch_no_valid", v_cyc.size() - nv, 0);
      check("glitch_no_ferr", f_cyc.size() - nf, 0);
      check("glitch_busy_cycles", busy_total - bb, 8);
      check("glitch_busy_low", busy, 1'b0);
      check("glitch_data", rx_data, 8'hA5);

      nv = v_cyc.size(); nf = f_cyc.size();
      send_bits({1'b0, 8'h3C, 1'b0}, 10, 16, 0, e0);
      repeat (30) @(posedge clock);
      #1;
      check("ferr_cnt", f_cyc.size() - nf, 1);
      check("ferr_edge", f_cyc[nf], e0 + 152);
      check("ferr_no_valid", v_cyc.size() - nv, 0);
      check("ferr_data_held", rx_data, 8'hA5);

      nv = v_cyc.size();
      send_bits({1'b1, 8'h00, 1'b0}, 10, 16, 0, e0);
      send_bits({1'b1, 8'hFF, 1'b0}, 10, 16, 0, e1);
      repeat (4) @(posedge clock);
      #1;
      check("b2b_valid_cnt", v_cyc.size() - nv, 2);
      check("b2b_first_edge", v_cyc[nv], e0 + 152);
      check("b2b_spacing", v_cyc[nv+1] - v_cyc[nv], 160);
      check("b2b_data0", v_dat[nv], 8'h00);
      check("b2b_data1", v_dat[nv+1], 8'hFF);
      check("b2b_data_final", rx_data, 8'hFF);

      send_bits({8'h55, 1'b0}, 4, 16, 0, e0);
      rx = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      check("mid_busy", busy, 1'b1);
      #2;
      reset = 1'b1;
      rx = 1'b1;
      #1;
      check("mid_rst_data", rx_data, 8'h00);
      check("mid_rst_valid", rx_valid, 1'b0);
      check("mid_rst_ferr", framing_error, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      nv = v_cyc.size(); nf = f_cyc.size();
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (200) @(posedge clock);
      #1;
      check("mid_no_valid", v_cyc.size() - nv, 0);
      check("mid_no_ferr", f_cyc.size() - nf, 0);
      check("mid_data_zero", rx_data, 8'h00);
      send_bits({1'b1, 8'h81, 1'b0}, 10, 16, 0, e0);
      repeat (4) @(posedge clock);
      #1;
      check("post_valid_cnt", v_cyc.size() - nv, 1);
      check("post_valid_edge", v_cyc[nv], e0 + 152);
      check("post_data", rx_data, 8'h81);

      n7 = v7_cyc.size();
      send_bits({1'b1, 7'h41, 1'b0}, 9, 5, 1, e0);
      repeat (4) @(posedge clock);
      #1;
      check("p7_valid_cnt", v7_cyc.size() - n7, 1);
      check("p7_valid_edge", v7_cyc[n7], e0 + 42);
      check("p7_data", d7, 7'h41);
      check("p7_no_ferr", f7, 1'b0);

      check("valid_ferr_exclusive", both_cnt, 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
